// File: rtl/sprite_mem_port_pkg.sv
// Shared definitions for the sprite memory read port.
// - Default widths (RGB444 pixel, 1K-word BRAM), client count, BRAM latency.
// - ch_w: width of a channel tag (at least 1 bit, even for a single client).
// - wrap_inc: round-robin successor of a channel index.
package sprite_mem_port_pkg;

  localparam int WIDTH_BASE_DEF = 12;
  localparam int DEPTH_BASE_DEF = 10;
  localparam int N_CH_DEF       = 4;
  localparam int RD_LAT_DEF     = 1;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wrap_inc(input int w, input int n);
    return (w + 1 >= n) ? 0 : w + 1;
  endfunction

endpackage

// File: rtl/sprite_mem_port_if.sv
// Client + BRAM side bundle of the sprite memory read port.
// - req/addr   : per-channel read request, addr held with req until ack
// - ack        : one-hot grant (combinational)
// - rvalid     : per-channel one-cycle completion pulse
// - rdata      : per-channel held read data
// - mem_addr   : registered BRAM address (addra)
// - mem_dout   : BRAM read data (douta)
// master = clients + BRAM side, slave = the port itself.
// Packed [ch][bit] arrays lay out exactly like the flat i*W +: W slicing.
interface sprite_mem_port_if
  import sprite_mem_port_pkg::*;
#(
  parameter int N_CH       = N_CH_DEF,
  parameter int DEPTH_BASE = DEPTH_BASE_DEF,
  parameter int WIDTH_BASE = WIDTH_BASE_DEF
);
  logic [N_CH-1:0]                 req;
  logic [N_CH-1:0][DEPTH_BASE-1:0] addr;
  logic [N_CH-1:0]                 ack;
  logic [N_CH-1:0]                 rvalid;
  logic [N_CH-1:0][WIDTH_BASE-1:0] rdata;
  logic [DEPTH_BASE-1:0]           mem_addr;
  logic [WIDTH_BASE-1:0]           mem_dout;

  modport master (output req, addr, mem_dout, input ack, rvalid, rdata, mem_addr);
  modport slave  (input req, addr, mem_dout, output ack, rvalid, rdata, mem_addr);
endinterface

// File: rtl/sprite_mem_port_rr_arbiter.sv
// Round-robin arbiter, purely combinational.
// - req : request vector
// - ptr : highest-priority index this cycle
// - gnt : one-hot grant, zero when no request
// - win : encoded winner (0 when any=0)
// - any : some request granted
module rr_arbiter
  import sprite_mem_port_pkg::*;
#(
  parameter int N  = N_CH_DEF,
  parameter int CW = ch_w(N)
)(
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [CW-1:0] win,
  output logic          any
);
  // One extra bit so ptr+k can be folded back below N without overflow.
  logic [CW:0] idx;

  always_comb begin
    gnt = '0;
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (CW+1)'(k);
      if (idx >= (CW+1)'(N)) idx = idx - (CW+1)'(N);
      if (!any && req[idx[CW-1:0]]) begin
        any                 = 1'b1;
        gnt[idx[CW-1:0]]    = 1'b1;
        win                 = idx[CW-1:0];
      end
    end
  end
endmodule

// File: rtl/sprite_mem_port.sv
// Multi-client read port in front of one single-port sprite BRAM.
// - clk, rst : rising-edge clock, synchronous active-high reset
// - bus      : client request/ack/return signals plus BRAM addra/douta
// One read issued per cycle, round-robin between clients. Each issued read
// carries a channel tag down a shift register matched to the BRAM latency,
// so the returning word is steered to its requester with fixed latency:
// ack in cycle 0 -> rvalid/rdata in cycle 2+RD_LAT.
module sprite_mem_port
  import sprite_mem_port_pkg::*;
#(
  parameter int WIDTH_BASE = WIDTH_BASE_DEF,
  parameter int DEPTH_BASE = DEPTH_BASE_DEF,
  parameter int N_CH       = N_CH_DEF,
  parameter int RD_LAT     = RD_LAT_DEF
)(
  input logic           clk,
  input logic           rst,
  sprite_mem_port_if.slave bus
);
  localparam int CW = ch_w(N_CH);

  logic [CW-1:0]                   rr_ptr;
  logic [N_CH-1:0]                 gnt;
  logic [CW-1:0]                   win;
  logic                            any;
  logic [DEPTH_BASE-1:0]           mem_addr_q;
  // Stage 0 aligns with mem_addr, stage RD_LAT with mem_dout.
  logic [RD_LAT:0]                 vld_pipe;
  logic [RD_LAT:0][CW-1:0]         ch_pipe;
  logic [N_CH-1:0]                 hit;
  logic [N_CH-1:0]                 rvalid_q;
  logic [N_CH-1:0][WIDTH_BASE-1:0] rdata_q;

  rr_arbiter #(.N(N_CH), .CW(CW)) u_arb (
    .req (bus.req),
    .ptr (rr_ptr),
    .gnt (gnt),
    .win (win),
    .any (any)
  );

  // Nothing is accepted while in reset, so the grant is masked there too.
  assign bus.ack      = rst ? '0 : gnt;
  assign bus.mem_addr = mem_addr_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = rdata_q;

  // Issue side: pointer, BRAM address, tag shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      mem_addr_q <= '0;
      vld_pipe   <= '0;
      ch_pipe    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[RD_LAT-1:0], any};
      ch_pipe  <= {ch_pipe[RD_LAT-1:0], win};
      if (any) begin
        rr_ptr     <= CW'(wrap_inc(int'(win), N_CH));
        mem_addr_q <= bus.addr[win];
      end
    end
  end

  // Return side: the tag leaving the pipe names the channel that owns mem_dout.
  always_comb begin
    hit = '0;
    for (int c = 0; c < N_CH; c++)
      hit[c] = vld_pipe[RD_LAT] && (ch_pipe[RD_LAT] == CW'(c));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= hit;
      for (int c = 0; c < N_CH; c++)
        if (hit[c]) rdata_q[c] <= bus.mem_dout;
    end
  end
endmodule

// File: tb/tb_sprite_mem_port.sv
// Bench for sprite_mem_port: directed scenarios plus a randomized phase,
// checked against a transaction-level model (grant search from a pointer,
// a queue of pending returns with due cycles, held per-channel data).
// A second instance with RD_LAT=2 covers the deeper BRAM option.
module tb_sprite_mem_port;
  localparam int N = 4, AW = 10, DW = 12, LAT1 = 1;

  typedef struct {
    int             due;
    int             ch;
    logic [DW-1:0]  data;
  } ret_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  sprite_mem_port_if #(.N_CH(N), .DEPTH_BASE(AW), .WIDTH_BASE(DW)) bif ();
  sprite_mem_port_if #(.N_CH(N), .DEPTH_BASE(AW), .WIDTH_BASE(DW)) b2 ();

  sprite_mem_port #(.WIDTH_BASE(DW), .DEPTH_BASE(AW), .N_CH(N), .RD_LAT(1)) dut (
    .clk (clk), .rst (rst), .bus (bif));
  sprite_mem_port #(.WIDTH_BASE(DW), .DEPTH_BASE(AW), .N_CH(N), .RD_LAT(2)) dut2 (
    .clk (clk), .rst (rst2), .bus (b2));

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return {2'b00, a} ^ 12'hA5A;
  endfunction

  // BRAM models: ROM behind RD_LAT registers.
  logic [DW-1:0] d2_p;
  always @(posedge clk) bif.mem_dout <= rom(bif.mem_addr);
  always @(posedge clk) begin
    d2_p        <= rom(b2.mem_addr);
    b2.mem_dout <= d2_p;
  end

  int nvec = 0, nmis = 0, now = 0, m_ptr = 0;
  logic [N-1:0]         cl_req = '0, keep = '0;
  logic [N-1:0][AW-1:0] cl_addr = '0;
  logic [N-1:0][DW-1:0] m_rdata = '0;
  logic [AW-1:0]        m_maddr = '0;
  logic [N-1:0]         last_ack, last_rv;
  logic [N-1:0]         alog [8];
  logic [N-1:0]         rlog [8];
  logic [DW-1:0]        dlog [8];
  ret_t                 pend [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of the RD_LAT=1 instance: check registered outputs against the
  // model, drive client inputs, check the grant, advance the model.
  task automatic cyc(input logic r);
    ret_t         nq [$];
    logic [N-1:0] erv, eack;
    int           w;
    @(posedge clk); #1;
    now++;
    erv = '0;
    nq  = {};
    foreach (pend[i]) begin
      if (pend[i].due == now) begin
        erv[pend[i].ch]     = 1'b1;
        m_rdata[pend[i].ch] = pend[i].data;
      end else nq.push_back(pend[i]);
    end
    pend    = nq;
    last_rv = bif.rvalid;
    chk("rvalid", 64'(bif.rvalid), 64'(erv));
    chk("rdata", 64'(bif.rdata), 64'(m_rdata));
    chk("mem_addr", 64'(bif.mem_addr), 64'(m_maddr));
    rst      = r;
    bif.req  = cl_req;
    bif.addr = cl_addr;
    #1;
    w = -1;
    if (!r)
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (w < 0 && cl_req[idx]) w = idx;
      end
    eack = '0;
    if (w >= 0) eack[w] = 1'b1;
    last_ack = bif.ack;
    chk("ack", 64'(bif.ack), 64'(eack));
    if (r) begin
      m_ptr   = 0;
      pend    = {};
      m_rdata = '0;
      m_maddr = '0;
    end else if (w >= 0) begin
      m_ptr   = (w + 1) % N;
      m_maddr = cl_addr[w];
      pend.push_back('{now + 2 + LAT1, w, rom(cl_addr[w])});
      if (!keep[w]) cl_req[w] = 1'b0;
    end
  endtask

  task automatic step2(input logic r, input logic [N-1:0] rq, input logic [AW-1:0] a2);
    @(posedge clk); #1;
    rst2       = r;
    b2.req     = rq;
    b2.addr[2] = a2;
    #1;
  endtask

  initial begin
    logic any_rv;
    int   got;
    bif.req  = '0;
    bif.addr = '0;
    b2.req   = '0;
    b2.addr  = '0;

    // Reset: requests present but no grant; outputs at reset values.
    cl_req = '1;
    cyc(1);
    chk("rst_ack", 64'(last_ack), 64'd0);
    cyc(1);
    chk("rst_state", 64'({bif.rvalid, bif.mem_addr}), 64'd0);
    cl_req = '0;
    cyc(0);

    // Single read, ch2 @ 0x03C.
    cl_addr[2] = 10'h03C;
    cl_req     = 4'b0100;
    cyc(0); chk("single_ack", 64'(last_ack), 64'h4);
    cyc(0); chk("single_maddr", 64'(bif.mem_addr), 64'h03C);
    cyc(0); chk("single_rv_early", 64'(last_rv), 64'h0);
    cyc(0); chk("single_rv", 64'(last_rv), 64'h4);
    chk("single_rdata", 64'(bif.rdata[2]), 64'hA66);
    cyc(0); chk("single_hold", 64'(bif.rdata[2]), 64'hA66);

    // Contention: all four request addrs 0..3 from rr_ptr=0.
    cyc(1);
    cl_addr = {10'd3, 10'd2, 10'd1, 10'd0};
    cl_req  = '1;
    for (int i = 0; i < 7; i++) begin
      cyc(0);
      alog[i] = last_ack;
      rlog[i] = last_rv;
    end
    for (int i = 0; i < 4; i++) begin
      chk("cont_ack", 64'(alog[i]), 64'(1) << i);
      chk("cont_rv", 64'(rlog[i+3]), 64'(1) << i);
    end
    chk("cont_rdata3", 64'(bif.rdata[3]), 64'hA59);

    // Fairness: ch0 and ch3 always requesting, ch1 joins later.
    cyc(1);
    keep    = 4'b1001;
    cl_req  = 4'b1001;
    cl_addr = {10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom)};
    for (int i = 0; i < 4; i++) begin
      cyc(0);
      alog[i] = last_ack;
    end
    chk("fair0", 64'(alog[0]), 64'h1);
    chk("fair1", 64'(alog[1]), 64'h8);
    chk("fair2", 64'(alog[2]), 64'h1);
    chk("fair3", 64'(alog[3]), 64'h8);
    cl_req[1] = 1'b1;
    got = -1;
    for (int i = 0; i < N && got < 0; i++) begin
      cyc(0);
      if (last_ack[1]) got = i;
    end
    chk("fair_ch1_bound", 64'(got >= 0), 64'd1);
    keep   = '0;
    cl_req = '0;
    for (int i = 0; i < 5; i++) cyc(0);

    // Back-to-back sole client ch1, addrs 5,6,7.
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      cl_req     = 4'b0010;
      cl_addr[1] = 10'(5 + i);
      cyc(0);
      alog[i] = last_ack;
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0);
      rlog[i] = last_rv;
      dlog[i] = bif.rdata[1];
    end
    for (int i = 0; i < 3; i++) begin
      chk("b2b_ack", 64'(alog[i]), 64'h2);
      chk("b2b_rv", 64'(rlog[i]), 64'h2);
    end
    chk("b2b_d0", 64'(dlog[0]), 64'hA5F);
    chk("b2b_d1", 64'(dlog[1]), 64'hA5C);
    chk("b2b_d2", 64'(dlog[2]), 64'hA5D);
    chk("b2b_rv_end", 64'(rlog[3]), 64'h0);

    // Reset mid-flight: grant ch0, reset next cycle, read must vanish.
    cl_req     = 4'b0001;
    cl_addr[0] = 10'h123;
    cyc(0); chk("mid_ack", 64'(last_ack), 64'h1);
    cyc(1);
    any_rv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(0);
      any_rv = any_rv | (|last_rv);
    end
    chk("mid_no_rv", 64'(any_rv), 64'd0);
    chk("mid_rdata", 64'(bif.rdata), 64'd0);
    chk("mid_maddr", 64'(bif.mem_addr), 64'd0);

    // Randomized traffic with occasional drops, address changes and resets.
    for (int n = 0; n < 300; n++) begin
      for (int c = 0; c < N; c++) begin
        if (!cl_req[c]) begin
          if ($urandom_range(1, 0) == 1) begin
            cl_req[c]  = 1'b1;
            cl_addr[c] = 10'($urandom);
          end
        end else begin
          int r;
          r = int'($urandom_range(15, 0));
          if (r == 0) cl_req[c] = 1'b0;
          else if (r < 3) cl_addr[c] = 10'($urandom);
        end
      end
      cyc($urandom_range(63, 0) == 0);
    end
    cl_req = '0;
    for (int i = 0; i < 6; i++) cyc(0);

    // RD_LAT=2 instance: single read latency and data hold.
    step2(1, 4'b0000, 10'h0);
    step2(0, 4'b0100, 10'h03C);
    chk("l2_ack", 64'(b2.ack), 64'h4);
    for (int c = 1; c <= 6; c++) begin
      step2(0, 4'b0000, 10'h0);
      rlog[c] = b2.rvalid;
      dlog[c] = b2.rdata[2];
    end
    chk("l2_rv1", 64'(rlog[1]), 64'h0);
    chk("l2_rv2", 64'(rlog[2]), 64'h0);
    chk("l2_rv3", 64'(rlog[3]), 64'h0);
    chk("l2_rv4", 64'(rlog[4]), 64'h4);
    chk("l2_d4", 64'(dlog[4]), 64'hA66);
    chk("l2_rv5", 64'(rlog[5]), 64'h0);
    chk("l2_d6", 64'(dlog[6]), 64'hA66);
    step2(0, 4'b0100, 10'h100);
    chk("l2_ack_b", 64'(b2.ack), 64'h4);
    for (int c = 1; c <= 4; c++) begin
      step2(0, 4'b0000, 10'h0);
      rlog[c] = b2.rvalid;
      dlog[c] = b2.rdata[2];
    end
    chk("l2_hold_b", 64'(dlog[3]), 64'hA66);
    chk("l2_rv_b", 64'(rlog[4]), 64'h4);
    chk("l2_d_b", 64'(dlog[4]), 64'hB5A);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
